// File: rtl/fc_forward_engine_if.sv
// Memory-side bus of the FC forward engine.
//   we / addr / data   : single write/read port (addr also drives reads)
//   re_data            : read data, valid one cycle after addr
//   fc1_com_end /
//   fc2_com_end        : bank select flags ({0,x}=bank0, {1,0}=bank1, {1,1}=bank2)
// master = engine side, slave = memory side.
interface fc_forward_engine_if;
  logic        we;
  logic [15:0] addr;
  logic [15:0] data;
  logic [15:0] re_data;
  logic        fc1_com_end;
  logic        fc2_com_end;

  modport master (
    output we, addr, data, fc1_com_end, fc2_com_end,
    input  re_data
  );

  modport slave (
    input  we, addr, data, fc1_com_end, fc2_com_end,
    output re_data
  );
endinterface

// File: rtl/fc_forward_engine.sv
// Forward-propagation sequencer for a two-layer fully connected classifier.
// Loads FRT_CELL inputs and layer-1 weights from bank 0, computes MID_CELL
// ReLU hidden cells, writes them to bank 1, computes BCK_CELL output cells
// from bank-1 weights and writes them to bank 2.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : one-cycle request, accepted only in IDLE
//   busy, done   : pass in progress / one-cycle completion pulse
//   mem          : memory bus (fc_forward_engine_if.master)
module fc_forward_engine #(
  parameter int FRT_CELL = 32,
  parameter int MID_CELL = 20,
  parameter int BCK_CELL = 10,
  parameter int FRAC     = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  fc_forward_engine_if.master        mem
);

  localparam int L1_N = FRT_CELL * MID_CELL;
  localparam int L2_N = MID_CELL * BCK_CELL;
  localparam int CW   = $clog2(L1_N + 2);
  localparam int M1   = (FRT_CELL > MID_CELL) ? FRT_CELL : MID_CELL;
  localparam int MAXC = (M1 > BCK_CELL) ? M1 : BCK_CELL;
  localparam int IW   = $clog2(MAXC);
  localparam int JW   = $clog2(FRT_CELL);
  localparam int HW   = $clog2(MID_CELL);
  localparam int OW   = $clog2(BCK_CELL);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_LDIN, S_L1_MAC, S_L1_WR, S_L2_MAC, S_L2_WR, S_DONE
  } state_t;

  // What the read issued in a given cycle is for; travels with the read
  // so the returning data can be routed without re-deriving the state.
  typedef enum logic [1:0] { K_NONE, K_LD, K_L1, K_L2 } kind_t;

  typedef struct packed {
    kind_t         kind;
    logic [IW-1:0] o;    // neuron index
    logic [IW-1:0] n;    // operand index within the neuron
  } tag_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]      o_q, o_d, n_q, n_d;
  logic [15:0]        addr_q, addr_d, data_q, data_d;
  logic               we_q, we_d, fc1_q, fc1_d, fc2_q, fc2_d;
  logic               busy_q, busy_d, done_q, done_d;
  tag_t               rd_q, rd_d;   // tag of the address currently driven
  tag_t               rt_q;         // tag of the data currently on re_data
  logic signed [31:0] acc_q, acc_d;

  logic signed [15:0] in_q  [FRT_CELL];
  logic signed [15:0] hid_q [MID_CELL];
  logic signed [15:0] out_q [BCK_CELL];

  // ---------------- datapath ----------------
  logic signed [31:0] a32, b32, full, prod, sum;
  logic signed [15:0] operand, sat16;
  logic               first, hid_wr, out_wr, in_wr;

  always_comb begin
    operand = '0;
    if (rt_q.kind == K_L1) operand = in_q[rt_q.n[JW-1:0]];
    else if (rt_q.kind == K_L2) operand = hid_q[rt_q.n[HW-1:0]];

    a32  = {{16{mem.re_data[15]}}, mem.re_data};
    b32  = {{16{operand[15]}}, operand};
    full = a32 * b32;
    prod = full >>> FRAC;

    first = (rt_q.n == '0);
    sum   = (first ? 32'sd0 : acc_q) + prod;

    if (sum > 32'sd32767)       sat16 = 16'sh7fff;
    else if (sum < -32'sd32768) sat16 = -16'sd32768;
    else                        sat16 = sum[15:0];

    acc_d = acc_q;
    if (rt_q.kind == K_L1 || rt_q.kind == K_L2) acc_d = sum;

    in_wr  = (rt_q.kind == K_LD);
    hid_wr = (rt_q.kind == K_L1) && (rt_q.n == IW'(FRT_CELL - 1));
    out_wr = (rt_q.kind == K_L2) && (rt_q.n == IW'(MID_CELL - 1));
  end

  always_ff @(posedge clk) begin
    if (in_wr)  in_q[rt_q.n[JW-1:0]]  <= mem.re_data;
    if (hid_wr) hid_q[rt_q.o[HW-1:0]] <= sat16[15] ? 16'sd0 : sat16;
    if (out_wr) out_q[rt_q.o[OW-1:0]] <= sat16;
  end

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = cnt_inc;
    o_d     = o_q;
    n_d     = n_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    fc1_d   = fc1_q;
    fc2_d   = fc2_q;
    rd_d    = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d    = S_L1_LDIN;
          fc1_d      = 1'b0;
          fc2_d      = 1'b0;
          n_d        = '0;
          addr_d     = '0;
          rd_d.kind  = K_LD;
        end
      end

      S_L1_LDIN: begin
        if (cnt_q == CW'(FRT_CELL)) begin
          state_d   = S_L1_MAC;
          cnt_d     = '0;
          o_d       = '0;
          n_d       = '0;
          addr_d    = 16'(FRT_CELL);
          rd_d.kind = K_L1;
        end else if (cnt_q < CW'(FRT_CELL - 1)) begin
          n_d       = n_q + IW'(1);
          addr_d    = addr_q + 16'd1;
          rd_d.kind = K_LD;
          rd_d.n    = n_d;
        end
      end

      S_L1_MAC: begin
        if (cnt_q == CW'(L1_N)) begin
          // drain cycle done; last hidden cell lands on this edge
          state_d = S_L1_WR;
          cnt_d   = '0;
          fc1_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = hid_q[0];
        end else if (cnt_q < CW'(L1_N - 1)) begin
          if (n_q == IW'(FRT_CELL - 1)) begin
            n_d = '0;
            o_d = o_q + IW'(1);
          end else begin
            n_d = n_q + IW'(1);
          end
          addr_d    = addr_q + 16'd1;
          rd_d.kind = K_L1;
          rd_d.o    = o_d;
          rd_d.n    = n_d;
        end
      end

      S_L1_WR: begin
        if (cnt_q == CW'(MID_CELL - 1)) begin
          state_d   = S_L2_MAC;
          cnt_d     = '0;
          o_d       = '0;
          n_d       = '0;
          addr_d    = 16'(MID_CELL);
          rd_d.kind = K_L2;
        end else begin
          we_d   = 1'b1;
          addr_d = 16'(cnt_inc);
          data_d = hid_q[cnt_inc[HW-1:0]];
        end
      end

      S_L2_MAC: begin
        if (cnt_q == CW'(L2_N)) begin
          state_d = S_L2_WR;
          cnt_d   = '0;
          fc2_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = out_q[0];
        end else if (cnt_q < CW'(L2_N - 1)) begin
          if (n_q == IW'(MID_CELL - 1)) begin
            n_d = '0;
            o_d = o_q + IW'(1);
          end else begin
            n_d = n_q + IW'(1);
          end
          addr_d    = addr_q + 16'd1;
          rd_d.kind = K_L2;
          rd_d.o    = o_d;
          rd_d.n    = n_d;
        end
      end

      S_L2_WR: begin
        if (cnt_q == CW'(BCK_CELL - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = 16'(cnt_inc);
          data_d = out_q[cnt_inc[OW-1:0]];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      fc1_q   <= 1'b0;
      fc2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      rt_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      fc1_q   <= fc1_d;
      fc2_q   <= fc2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      rt_q    <= rd_q;
      acc_q   <= acc_d;
    end
  end

  assign mem.we          = we_q;
  assign mem.addr        = addr_q;
  assign mem.data        = data_q;
  assign mem.fc1_com_end = fc1_q;
  assign mem.fc2_com_end = fc2_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
